// File: rtl/fuzzy_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fuzzy_sweep_pkg
// Description : Shared types and default constants for the fuzzy sweep engine.
// Revision    : 1.0 - initial release
// ============================================================================
package fuzzy_sweep_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OFFER  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_MIN_VAL    = 1;
  localparam int unsigned DEF_MAX_VAL    = 254;
  localparam int unsigned DEF_SETTLE_CYC = 33;
  localparam int unsigned CHK_W          = 16;

endpackage
`default_nettype wire

// File: rtl/fuzzy_sweep_if.sv
`default_nettype none
// ============================================================================
// Module      : fuzzy_sweep_if
// Description : Result stream (valid/ready with last-qualifier) between the
//               sweep engine (master) and the result sink (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fuzzy_sweep_if
  import fuzzy_sweep_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/fuzzy_sweep_odometer.sv
`default_nettype none
// ============================================================================
// Module      : fuzzy_sweep_odometer
// Description : N_IN-digit clamped grid counter. Channel N_IN-1 is the fastest
//               digit; a digit whose next value would exceed MAX_VAL wraps to
//               MIN_VAL and carries into the next slower channel.
// Revision    : 1.0 - initial release
// ============================================================================
module fuzzy_sweep_odometer
  import fuzzy_sweep_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned N_IN    = 2,
  parameter int unsigned MIN_VAL = DEF_MIN_VAL,
  parameter int unsigned MAX_VAL = DEF_MAX_VAL
) (
  input  wire logic                     clk_0,
  input  wire logic                     Srst,
  input  wire logic                     load,
  input  wire logic                     advance,
  input  wire logic [DATA_W-1:0]        step,
  output logic      [N_IN*DATA_W-1:0]   vec,
  output logic                          last
);

  localparam logic [DATA_W-1:0] MIN_V   = DATA_W'(MIN_VAL);
  localparam logic [DATA_W:0]   MAX_EXT = (DATA_W+1)'(MAX_VAL);

  // carry[k+1] is the carry into channel k; the fastest channel always steps
  logic [N_IN:0] carry;
  assign carry[N_IN] = 1'b1;

  // Every channel carrying out means the current point is the final one
  assign last = carry[0];

  for (genvar k = 0; k < N_IN; k++) begin : g_ch
    logic [DATA_W-1:0] val;
    logic [DATA_W:0]   sum;
    logic              wrap;
    logic [DATA_W-1:0] nxt;

    // One extra bit so v+step can never overflow before the clamp compare
    assign sum      = {1'b0, val} + {1'b0, step};
    assign wrap     = (sum > MAX_EXT);
    assign carry[k] = carry[k+1] & wrap;
    assign nxt      = !carry[k+1] ? val : (wrap ? MIN_V : sum[DATA_W-1:0]);

    // Channel register: reload to floor on sweep start, step on grid advance
    always_ff @(posedge clk_0 or negedge Srst) begin
      if (!Srst) begin
        val <= MIN_V;
      end else if (load) begin
        val <= MIN_V;
      end else if (advance) begin
        val <= nxt;
      end
    end

    assign vec[k*DATA_W +: DATA_W] = val;
  end

endmodule
`default_nettype wire

// File: rtl/fuzzy_sweep_engine.sv
`default_nettype none
// ============================================================================
// Module      : fuzzy_sweep_engine
// Description : Sweeps the controller inputs over a clamped grid, waits a
//               settle time per point, captures fz_out and offers it on a
//               valid/ready result port.
//               Optional macro FUZZY_SWEEP_CHECKSUM_EN enables a running
//               16-bit sum of transferred results on chk_out.
// Revision    : 1.0 - initial release
// ============================================================================
module fuzzy_sweep_engine
  import fuzzy_sweep_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned N_IN       = 2,
  parameter int unsigned MIN_VAL    = DEF_MIN_VAL,
  parameter int unsigned MAX_VAL    = DEF_MAX_VAL,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  wire logic                   clk_0,
  input  wire logic                   Srst,
  input  wire logic                   start,
  input  wire logic                   abort,
  input  wire logic [DATA_W-1:0]      step,
  output logic      [N_IN*DATA_W-1:0] fz_in,
  input  wire logic [DATA_W-1:0]      fz_out,
  fuzzy_sweep_if.master               res,
  output logic                        busy,
  output logic                        done,
  output logic      [CHK_W-1:0]       chk_out
);

  localparam int unsigned     CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] step_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;

  logic accept;
  logic xfer;
  logic pt_last;

  // abort outranks both a new start and a result transfer
  assign accept = (state == ST_IDLE) && start && !abort;
  assign xfer   = (state == ST_OFFER) && valid_q && res.ready && !abort;

  // The final point is not advanced so fz_in holds it through DONE
  fuzzy_sweep_odometer #(
    .DATA_W  (DATA_W),
    .N_IN    (N_IN),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_odo (
    .clk_0   (clk_0),
    .Srst    (Srst),
    .load    (accept),
    .advance (xfer && !pt_last),
    .step    (step_q),
    .vec     (fz_in),
    .last    (pt_last)
  );

  // Sweep sequencer with registered handshake and status outputs
  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      step_q  <= DATA_W'(1);
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state   <= ST_IDLE;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              step_q <= (step == '0) ? DATA_W'(1) : step;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (cnt == CNT_LAST) begin
              data_q  <= fz_out;
              last_q  <= pt_last;
              valid_q <= 1'b1;
              state   <= ST_OFFER;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_OFFER: begin
            if (xfer) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              cnt     <= '0;
              if (last_q) begin
                done_q <= 1'b1;
                state  <= ST_DONE;
              end else begin
                state  <= ST_SETTLE;
              end
            end
          end
          default: begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign res.valid = valid_q;
  assign res.data  = data_q;
  assign res.last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef FUZZY_SWEEP_CHECKSUM_EN
  logic [CHK_W-1:0] chk_q;

  // Running sum of transferred results, restarted by each accepted start
  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) begin
      chk_q <= '0;
    end else if (accept) begin
      chk_q <= '0;
    end else if (xfer) begin
      chk_q <= chk_q + CHK_W'(data_q);
    end
  end

  assign chk_out = chk_q;
`else
  assign chk_out = '0;
`endif

endmodule
`default_nettype wire
